roc_encoder_cs: RTL
===================

Name: roc_encoder_cs

Overview:
- Parametrised rank-order-coding (ROC) encoder. It counting-sorts the pixel indices of a static input image by intensity and streams them as AER addresses over a valid/ready link into the SNN core.
- Sits between the image source and the AER input controller. Before each image it emits a configurable preamble of reset events.
- Additions over the previous generation: runtime sort direction, an intensity threshold that drops dim pixels, a true valid/ready handshake, a clean abort, correctly sized histogram counters, and an emitted-event count.

Parameters:
- IMAGE_SIZE, 256, number of pixels per image
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel index width
- PIXEL_BITS, 8, intensity width; NUM_BINS = 2**PIXEL_BITS
- AER_WIDTH, 10, AER address width; must be >= IMAGE_SIZE_BITS
- N_PREAMBLE, 2, reset events sent before the pixel stream (0 allowed)
- PREAMBLE_ADDR, 10'h1FF, address carried by each preamble event

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- IMAGE  in  PIXEL_BITS x IMAGE_SIZE (unpacked)  pixel intensities; must stay stable while BUSY
- START  in  1  begin encoding; sampled in IDLE only
- DESCENDING  in  1  1 = brightest first, 0 = dimmest first; latched at START
- THRESHOLD  in  PIXEL_BITS  pixels with value < THRESHOLD are excluded; latched at START
- ABORT  in  1  stop encoding (inference finished)
- AER_ADDR  out  AER_WIDTH  event address (pixel index zero-extended, or PREAMBLE_ADDR)
- AER_VALID  out  1  event valid
- AER_READY  in  1  downstream accepts event
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse on return to IDLE (normal completion or abort)
- EMIT_COUNT  out  IMAGE_SIZE_BITS+1  pixel events accepted for the current/last image

Behaviour:
- Reset: state IDLE; AER_VALID=0; AER_ADDR=0; BUSY=0; DONE=0; EMIT_COUNT=0; histogram and index buffer need not be cleared.
- A transfer occurs when AER_VALID && AER_READY. While AER_VALID=1 and no transfer has occurred, AER_ADDR is held stable and AER_VALID is never retracted.
- FSM states: IDLE, PREAMBLE, CLEAR, HIST, PREFIX, SCATTER, FETCH, SEND.
- IDLE: START=1 -> latch DESCENDING/THRESHOLD, clear EMIT_COUNT. Go to PREAMBLE if N_PREAMBLE>0, else CLEAR. START while BUSY is ignored.
- PREAMBLE: AER_VALID=1, AER_ADDR=PREAMBLE_ADDR. After N_PREAMBLE transfers -> CLEAR.
- CLEAR: zero all NUM_BINS histogram bins, one bin per cycle (NUM_BINS cycles) -> HIST.
- HIST: one pixel per cycle, index 0..IMAGE_SIZE-1. If IMAGE[i] >= THRESHOLD, increment hist[IMAGE[i]]. Bins are IMAGE_SIZE_BITS+1 wide, so every pixel in one bin cannot overflow. IMAGE_SIZE cycles -> PREFIX.
- PREFIX: exclusive running sum over bins, one bin per cycle (NUM_BINS cycles). Visit order is NUM_BINS-1 down to 0 if DESCENDING, else 0 up. Each visit sets hist[v] = running start position. The final total K is registered -> SCATTER.
- SCATTER: pixels ascending 0..IMAGE_SIZE-1. Each included pixel i is written to idx_buf[hist[IMAGE[i]]], then that bin is incremented. Result is a stable sort: equal intensities come out lowest index first. IMAGE_SIZE cycles.
- After SCATTER: if K==0 -> IDLE with DONE. Otherwise rank pointer r=0 -> FETCH.
- FETCH: issue registered read of idx_buf[r] (1 cycle) -> SEND.
- SEND: AER_VALID=1, AER_ADDR=idx_buf[r]. On transfer: EMIT_COUNT++, r++. If r==K-1 or an abort is pending -> IDLE with DONE; else -> FETCH.
- Throughput: one pixel event per 2 cycles with AER_READY held high.
- ABORT in PREAMBLE/SEND while AER_VALID=1: sets abort-pending; the current event is completed, then -> IDLE with DONE.
- ABORT in any other non-IDLE state: -> IDLE next cycle with DONE, no further events. ABORT in IDLE: no effect.
- ABORT and START in the same IDLE cycle: START wins.
- Latency START -> first pixel AER_VALID with AER_READY=1: 1 + N_PREAMBLE + NUM_BINS + IMAGE_SIZE + NUM_BINS + IMAGE_SIZE + 1 (FETCH) cycles.
- Async reset mid-operation returns to IDLE immediately with all outputs at reset values. No DONE pulse is generated.

Decomposition:
- Shared package snn_enc_pkg: state enum roc_state_t, and the AER preamble default constant reused by other encoders.
- One sub-module: roc_index_ram. Simple dual-port IMAGE_SIZE x IMAGE_SIZE_BITS buffer with synchronous write and registered read. Holds the sorted indices.
- Histogram stays in the top level (read-modify-write with combinational read).

Test Plan:
- IMAGE_SIZE=8, pixels {3,7,7,0,5,1,7,2}, DESCENDING=1, THRESHOLD=0, N_PREAMBLE=2, READY=1 -> events 1FF,1FF,1,2,6,4,0,7,5,3; then DONE; EMIT_COUNT=8.
- Same image, DESCENDING=0, THRESHOLD=2 -> 7,0,4,1,2,6; EMIT_COUNT=6.
- All pixels < THRESHOLD -> only the 2 preamble events, DONE, EMIT_COUNT=0, AER_VALID never high afterwards.
- Random AER_READY backpressure (30% duty) -> AER_ADDR stable while VALID && !READY; sequence identical to the READY=1 run.
- ABORT pulsed while 3rd pixel event is stalled (READY=0) -> that event completes when READY=1, then DONE; EMIT_COUNT=3; START ignored while BUSY.
- IMAGE_SIZE=256 with all pixels equal 255 -> bin reaches 256 without overflow; events 0..255 in order; RST_N asserted mid-SEND -> outputs return to reset values next edge.

Source files
------------

// File: rtl/snn_enc_pkg.sv
// Types and constants shared by the SNN input encoders.
// The preamble address is reused by every encoder that feeds the AER input controller.
package snn_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_CLEAR,
    ST_HIST,
    ST_PREFIX,
    ST_SCATTER,
    ST_FETCH,
    ST_SEND
  } roc_state_t;

  localparam logic [9:0] AER_PREAMBLE_ADDR_DEFAULT = 10'h1FF;

endpackage

// File: rtl/roc_index_ram.sv
// Simple dual-port buffer holding the sorted pixel indices.
// Writes are synchronous and the read data is registered.
module roc_index_ram
  import snn_enc_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int DATA_BITS = ADDR_BITS
) (
  input  logic                 CLK,
  input  logic                 WR_EN,
  input  logic [ADDR_BITS-1:0] WR_ADDR,
  input  logic [DATA_BITS-1:0] WR_DATA,
  input  logic                 RD_EN,
  input  logic [ADDR_BITS-1:0] RD_ADDR,
  output logic [DATA_BITS-1:0] RD_DATA
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      mem[WR_ADDR] <= WR_DATA;
    end
    if (RD_EN) begin
      RD_DATA <= mem[RD_ADDR];
    end
  end

endmodule

// File: rtl/roc_encoder_cs.sv
// Rank-order-coding encoder: counting-sorts pixel indices by intensity and
// streams them as AER events, preceded by a preamble of reset events.
module roc_encoder_cs
  import snn_enc_pkg::*;
#(
  parameter int                   IMAGE_SIZE      = 256,
  parameter int                   IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int                   PIXEL_BITS      = 8,
  parameter int                   AER_WIDTH       = 10,
  parameter int                   N_PREAMBLE      = 2,
  parameter logic [AER_WIDTH-1:0] PREAMBLE_ADDR   = AER_WIDTH'(AER_PREAMBLE_ADDR_DEFAULT)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [PIXEL_BITS-1:0]      IMAGE [IMAGE_SIZE],
  input  logic                       START,
  input  logic                       DESCENDING,
  input  logic [PIXEL_BITS-1:0]      THRESHOLD,
  input  logic                       ABORT,
  output logic [AER_WIDTH-1:0]       AER_ADDR,
  output logic                       AER_VALID,
  input  logic                       AER_READY,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [IMAGE_SIZE_BITS:0]   EMIT_COUNT
);

  localparam int NUM_BINS = 2 ** PIXEL_BITS;
  localparam int CNT_BITS = IMAGE_SIZE_BITS + 1;
  localparam int PRE_BITS = (N_PREAMBLE > 1) ? $clog2(N_PREAMBLE) : 1;

  roc_state_t state;

  logic                       desc_q;
  logic [PIXEL_BITS-1:0]      thr_q;
  logic [PRE_BITS-1:0]        pre_cnt;
  logic [PIXEL_BITS-1:0]      bin_cnt;
  logic [IMAGE_SIZE_BITS-1:0] pix_idx;
  logic [CNT_BITS-1:0]        running;
  logic [CNT_BITS-1:0]        k_total;
  logic [IMAGE_SIZE_BITS-1:0] rank;
  logic                       abort_pend;
  logic                       valid_q;
  logic [AER_WIDTH-1:0]       addr_q;
  logic                       done_q;
  logic [CNT_BITS-1:0]        emit_q;

  // Bins are one bit wider than a pixel index so a full image in one bin fits.
  logic [CNT_BITS-1:0]        hist [NUM_BINS];

  logic [PIXEL_BITS-1:0]      cur_pix;
  logic                       pix_in;
  logic [PIXEL_BITS-1:0]      prefix_bin;
  logic [CNT_BITS-1:0]        prefix_val;
  logic [CNT_BITS-1:0]        pix_bin_val;
  logic                       bin_last;
  logic                       pix_last;
  logic                       pre_last;
  logic                       rank_last;
  logic                       xfer;
  logic                       stop_now;
  logic [IMAGE_SIZE_BITS-1:0] rd_data;

  assign cur_pix     = IMAGE[pix_idx];
  assign pix_in      = (cur_pix >= thr_q);
  assign prefix_bin  = bin_cnt ^ {PIXEL_BITS{desc_q}};
  assign prefix_val  = hist[prefix_bin];
  assign pix_bin_val = hist[cur_pix];
  assign bin_last    = (bin_cnt == {PIXEL_BITS{1'b1}});
  assign pix_last    = (pix_idx == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1));
  assign pre_last    = (int'(pre_cnt) == N_PREAMBLE - 1);
  assign rank_last   = ({1'b0, rank} == (k_total - CNT_BITS'(1)));
  assign xfer        = valid_q && AER_READY;
  assign stop_now    = abort_pend || ABORT;

  roc_index_ram #(
    .DEPTH     (IMAGE_SIZE),
    .ADDR_BITS (IMAGE_SIZE_BITS),
    .DATA_BITS (IMAGE_SIZE_BITS)
  ) u_index_ram (
    .CLK     (CLK),
    .WR_EN   ((state == ST_SCATTER) && pix_in),
    .WR_ADDR (pix_bin_val[IMAGE_SIZE_BITS-1:0]),
    .WR_DATA (pix_idx),
    .RD_EN   (state == ST_FETCH),
    .RD_ADDR (rank),
    .RD_DATA (rd_data)
  );

  // Histogram read-modify-write: clear, count, convert to start offsets, then
  // bump each bin as its pixels are scattered so equal values stay index-ordered.
  always_ff @(posedge CLK) begin
    case (state)
      ST_CLEAR:   hist[bin_cnt] <= '0;
      ST_HIST:    if (pix_in) hist[cur_pix] <= pix_bin_val + CNT_BITS'(1);
      ST_PREFIX:  hist[prefix_bin] <= running;
      ST_SCATTER: if (pix_in) hist[cur_pix] <= pix_bin_val + CNT_BITS'(1);
      default:    ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      desc_q     <= 1'b0;
      thr_q      <= '0;
      pre_cnt    <= '0;
      bin_cnt    <= '0;
      pix_idx    <= '0;
      running    <= '0;
      k_total    <= '0;
      rank       <= '0;
      abort_pend <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      emit_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            desc_q     <= DESCENDING;
            thr_q      <= THRESHOLD;
            emit_q     <= '0;
            abort_pend <= 1'b0;
            pre_cnt    <= '0;
            bin_cnt    <= '0;
            pix_idx    <= '0;
            if (N_PREAMBLE > 0) begin
              state   <= ST_PREAMBLE;
              valid_q <= 1'b1;
              addr_q  <= PREAMBLE_ADDR;
            end else begin
              state <= ST_CLEAR;
            end
          end
        end

        // An abort while an event is on the link waits for that event to be taken.
        ST_PREAMBLE: begin
          if (ABORT) abort_pend <= 1'b1;
          if (xfer) begin
            if (stop_now) begin
              state   <= ST_IDLE;
              valid_q <= 1'b0;
              addr_q  <= '0;
              done_q  <= 1'b1;
            end else if (pre_last) begin
              state   <= ST_CLEAR;
              valid_q <= 1'b0;
              addr_q  <= '0;
            end else begin
              pre_cnt <= pre_cnt + PRE_BITS'(1);
            end
          end
        end

        ST_CLEAR: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            bin_cnt <= bin_cnt + PIXEL_BITS'(1);
            if (bin_last) begin
              state   <= ST_HIST;
              pix_idx <= '0;
            end
          end
        end

        ST_HIST: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            pix_idx <= pix_idx + IMAGE_SIZE_BITS'(1);
            if (pix_last) begin
              state   <= ST_PREFIX;
              pix_idx <= '0;
              bin_cnt <= '0;
              running <= '0;
            end
          end
        end

        ST_PREFIX: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            running <= running + prefix_val;
            bin_cnt <= bin_cnt + PIXEL_BITS'(1);
            if (bin_last) begin
              state   <= ST_SCATTER;
              k_total <= running + prefix_val;
              pix_idx <= '0;
            end
          end
        end

        ST_SCATTER: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            pix_idx <= pix_idx + IMAGE_SIZE_BITS'(1);
            if (pix_last) begin
              pix_idx <= '0;
              rank    <= '0;
              if (k_total == '0) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else begin
                state <= ST_FETCH;
              end
            end
          end
        end

        ST_FETCH: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            state   <= ST_SEND;
            valid_q <= 1'b1;
          end
        end

        ST_SEND: begin
          if (ABORT) abort_pend <= 1'b1;
          if (xfer) begin
            emit_q  <= emit_q + CNT_BITS'(1);
            valid_q <= 1'b0;
            if (rank_last || stop_now) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= ST_FETCH;
              rank  <= rank + IMAGE_SIZE_BITS'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // The index RAM's output register only updates in FETCH, so it stays stable through SEND.
  assign AER_ADDR   = (state == ST_SEND) ? AER_WIDTH'(rd_data) : addr_q;
  assign AER_VALID  = valid_q;
  assign BUSY       = (state != ST_IDLE);
  assign DONE       = done_q;
  assign EMIT_COUNT = emit_q;

endmodule
